// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
// Requester-side handshake bundle for alu_share_arbiter.
//   req0_*/req1_* : operation requests (valid/ready, operands a/b, carry-in, opcode)
//   rsp0_*/rsp1_* : per-requester response handshake (valid/ready)
//   rsp_out/cout  : captured ALU result, shared by both response ports
// Modports:
//   slave  : the arbiter (accepts requests, drives responses)
//   master : the requester side / bench (drives requests, takes responses)
interface alu_share_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int OPW   = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_cin;
  logic [OPW-1:0]   req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_cin;
  logic [OPW-1:0]   req1_op;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_out;
  logic             rsp_cout;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin, req0_op,
    input  req1_valid, req1_a, req1_b, req1_cin, req1_op,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_out, rsp_cout
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin, req0_op,
    output req1_valid, req1_a, req1_b, req1_cin, req1_op,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_out, rsp_cout
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one combinational logical ALU between two requesters. The winner's
// operands are latched into registers that drive the ALU, the ALU result is
// captured one cycle later and handed back to the winner over valid/ready.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : request/response handshakes and captured result
//   alu_a/b/cin/op  : registered operands to the ALU
//   alu_out/cout    : ALU result inputs
//   busy            : high whenever an operation is in flight (state != IDLE)
// Build option:
//   ARB_ROUND_ROBIN_EN defined   -> on contention the requester that did not
//                                   win last time gets the grant
//   ARB_ROUND_ROBIN_EN undefined -> fixed priority, req0 beats req1
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; ready offered to the winner only
// EXEC  | operands stable on alu_*; ALU result captured at end of cycle
// RESP  | rspN_valid to the granted requester until it takes the result
module alu_share_arbiter #(
  parameter int WIDTH = 4,
  parameter int OPW   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_share_arbiter_if.slave bus,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic              alu_cin,
  output logic [OPW-1:0]    alu_op,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              alu_cout,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             grant_q;
  logic             last_grant_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic             alu_cin_q;
  logic [OPW-1:0]   alu_op_q;
  logic [WIDTH-1:0] rsp_out_q;
  logic             rsp_cout_q;

  logic is_idle;
  logic any_valid;
  logic both_pick;
  logic win;
  logic hs;
  logic rsp_take;

  // Which requester wins when both are valid.
`ifdef ARB_ROUND_ROBIN_EN
  assign both_pick = ~last_grant_q;
`else
  // last_grant is tracked in both builds; fixed priority masks it out.
  assign both_pick = last_grant_q & 1'b0;
`endif

  always_comb begin
    win = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      win = both_pick;
    end else if (bus.req1_valid) begin
      win = 1'b1;
    end
  end

  assign is_idle        = (state_q == IDLE);
  assign any_valid      = bus.req0_valid | bus.req1_valid;
  assign bus.req0_ready = is_idle & any_valid & ~win;
  assign bus.req1_ready = is_idle & win;
  // In IDLE the winner is always offered ready, so any valid request handshakes.
  assign hs             = is_idle & any_valid;

  assign bus.rsp0_valid = (state_q == RESP) & ~grant_q;
  assign bus.rsp1_valid = (state_q == RESP) &  grant_q;
  assign rsp_take       = grant_q ? (bus.rsp1_valid & bus.rsp1_ready)
                                  : (bus.rsp0_valid & bus.rsp0_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_take) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cin_q    <= 1'b0;
      alu_op_q     <= '0;
      rsp_out_q    <= '0;
      rsp_cout_q   <= 1'b0;
    end else begin
      if (hs) begin
        grant_q   <= win;
        alu_a_q   <= win ? bus.req1_a   : bus.req0_a;
        alu_b_q   <= win ? bus.req1_b   : bus.req0_b;
        alu_cin_q <= win ? bus.req1_cin : bus.req0_cin;
        alu_op_q  <= win ? bus.req1_op  : bus.req0_op;
      end
      if (state_q == EXEC) begin
        rsp_out_q  <= alu_out;
        rsp_cout_q <= alu_cout;
      end
      if ((state_q == RESP) && rsp_take) begin
        last_grant_q <= grant_q;
      end
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_cin      = alu_cin_q;
  assign alu_op       = alu_op_q;
  assign bus.rsp_out  = rsp_out_q;
  assign bus.rsp_cout = rsp_cout_q;
  assign busy         = ~is_idle;

endmodule
